cla_tree_adder_32: RTL and testbench

- 32-bit carry-lookahead adder built as a tree: 32 bit-level generate/propagate cells, four 8-bit lookahead groups, and one top-level lookahead over the four groups.
- Produces the sum, the per-bit carry-out vector, and the word-level group generate/propagate.
- Results are registered once.
- Used as the integer add datapath wherever a low-depth 32-bit adder with an exposed carry chain is needed.

---
 rtl/cla_tree_adder_32_if.sv | 21 ++
 rtl/cla_tree_adder_32.sv | 112 +++++++++++
 tb/tb_cla_tree_adder_32.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cla_tree_adder_32_if.sv
// Operand/result bundle for the 32-bit tree carry-lookahead adder.
// The master drives operands and carry-in; the adder drives the results.
interface cla_tree_adder_32_if;
    logic        c0;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] c;
    logic        g;
    logic        p;

    modport master (
        output c0, a, b,
        input  s, c, g, p
    );

    modport slave (
        input  c0, a, b,
        output s, c, g, p
    );
endinterface

// File: rtl/cla_tree_adder_32.sv
// 32-bit carry-lookahead adder: bit g/p cells, four 8-bit prefix-tree
// groups, one lookahead level over the groups, registered outputs.
module cla_tree_adder_32 (
    input  logic                 clk,
    input  logic                 rst,
    cla_tree_adder_32_if.slave   bus
);
    logic [31:0] gb, pb;
    logic [31:0] pre_g, pre_p;
    logic [3:0]  grp_g, grp_p;
    logic [3:0]  cg;
    logic [31:0] co, ci;
    logic [7:0]  lg, lp, ng, np;
    logic        g01, g23;

    logic [31:0] s_d, s_q;
    logic [31:0] c_d, c_q;
    logic        g_d, g_q;
    logic        p_d, p_q;

    // Per-group prefix tree (spans 1, 2, 4) gives G/P of bits [j:0] for
    // every j, so each internal carry depends only on g/p and group cin.
    always_comb begin
        gb    = bus.a & bus.b;
        pb    = bus.a ^ bus.b;
        pre_g = '0;
        pre_p = '0;
        grp_g = '0;
        grp_p = '0;
        lg    = '0;
        lp    = '0;
        ng    = '0;
        np    = '0;
        for (int k = 0; k < 4; k++) begin
            lg = gb[8*k +: 8];
            lp = pb[8*k +: 8];
            for (int lvl = 0; lvl < 3; lvl++) begin
                ng = lg;
                np = lp;
                for (int j = 0; j < 8; j++) begin
                    if (j >= (1 << lvl)) begin
                        ng[j] = lg[j] | (lp[j] & lg[j - (1 << lvl)]);
                        np[j] = lp[j] & lp[j - (1 << lvl)];
                    end
                end
                lg = ng;
                lp = np;
            end
            pre_g[8*k +: 8] = lg;
            pre_p[8*k +: 8] = lp;
            grp_g[k]        = lg[7];
            grp_p[k]        = lp[7];
        end
    end

    // Group carry-ins expanded from c0, not chained through each other.
    always_comb begin
        cg[0] = bus.c0;
        cg[1] = grp_g[0]
              | (grp_p[0] & bus.c0);
        cg[2] = grp_g[1]
              | (grp_p[1] & grp_g[0])
              | (grp_p[1] & grp_p[0] & bus.c0);
        cg[3] = grp_g[2]
              | (grp_p[2] & grp_g[1])
              | (grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[2] & grp_p[1] & grp_p[0] & bus.c0);
    end

    always_comb begin
        co = '0;
        ci = '0;
        for (int i = 0; i < 32; i++) begin
            co[i] = pre_g[i] | (pre_p[i] & cg[i >> 3]);
        end
        for (int i = 0; i < 32; i++) begin
            if ((i % 8) == 0) begin
                ci[i] = cg[i >> 3];
            end else begin
                ci[i] = co[i - 1];
            end
        end
    end

    always_comb begin
        g01 = grp_g[1] | (grp_p[1] & grp_g[0]);
        g23 = grp_g[3] | (grp_p[3] & grp_g[2]);
        s_d = pb ^ ci;
        c_d = co;
        g_d = g23 | (grp_p[3] & grp_p[2] & g01);
        p_d = &grp_p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
            c_q <= '0;
            g_q <= 1'b0;
            p_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
            g_q <= g_d;
            p_q <= p_d;
        end
    end

    assign bus.s = s_q;
    assign bus.c = c_q;
    assign bus.g = g_q;
    assign bus.p = p_q;
endmodule

// File: tb/tb_cla_tree_adder_32.sv
// Self-checking bench for cla_tree_adder_32: reset, directed table,
// small-add sweep, mid-cycle reset and random operands.
module tb_cla_tree_adder_32;
    logic clk = 1'b0;
    logic rst = 1'b0;

    cla_tree_adder_32_if bus ();

    cla_tree_adder_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] c;
        logic        g;
        logic        p;
    } res_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        c0;
        res_t        exp;
    } vec_t;

    res_t sb_q[$];
    int   pass_n  = 0;
    int   total_n = 0;
    vec_t tbl[10];

    function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                   logic c0);
        res_t        r;
        logic [63:0] m;
        logic [63:0] t;
        t   = {32'd0, a} + {32'd0, b} + {63'd0, c0};
        r.s = t[31:0];
        r.c = '0;
        for (int i = 0; i < 32; i++) begin
            m = (64'd1 << (i + 1)) - 64'd1;
            t = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c0};
            r.c[i] = t[i + 1];
        end
        t   = {32'd0, a} + {32'd0, b};
        r.g = t[32];
        r.p = &(a ^ b);
        return r;
    endfunction

    function automatic res_t outs();
        res_t r;
        r.s = bus.s;
        r.c = bus.c;
        r.g = bus.g;
        r.p = bus.p;
        return r;
    endfunction

    task automatic check(string name, res_t got, res_t exp);
        total_n++;
        if (got === exp) begin
            pass_n++;
        end else begin
            $display("FAIL %s: got s=%h c=%h g=%b p=%b, want s=%h c=%h g=%b p=%b",
                     name, got.s, got.c, got.g, got.p,
                     exp.s, exp.c, exp.g, exp.p);
        end
    endtask

    task automatic drive(string name, logic [31:0] a, logic [31:0] b,
                         logic c0, res_t exp);
        @(negedge clk);
        bus.a  = a;
        bus.b  = b;
        bus.c0 = c0;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total_n++;
            $display("FAIL %s: scoreboard empty, got s=%h want an entry",
                     name, bus.s);
        end else begin
            check(name, outs(), sb_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        res_t        zero;
        res_t        e;
        zero = '0;

        tbl[0] = '{"byte_chain", 32'h04, 32'h1F, 1'b0,
                   '{32'h00000023, 32'h0000001C, 1'b0, 1'b0}};
        tbl[1] = '{"wrap_plus1", 32'hFFFFFFFF, 32'h1, 1'b0,
                   '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0}};
        tbl[2] = '{"wrap_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                   '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0}};
        tbl[3] = '{"prop_c0_0", 32'hFFFFFFFF, 32'h0, 1'b0,
                   '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1}};
        tbl[4] = '{"prop_c0_1", 32'hFFFFFFFF, 32'h0, 1'b1,
                   '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1}};
        tbl[5] = '{"grp_b0", 32'h000000FF, 32'h1, 1'b0,
                   '{32'h00000100, 32'h000000FF, 1'b0, 1'b0}};
        tbl[6] = '{"grp_b2", 32'h00FFFFFF, 32'h1, 1'b0,
                   '{32'h01000000, 32'h00FFFFFF, 1'b0, 1'b0}};
        tbl[7] = '{"small_5", 32'h5, 32'h00010013, 1'b0,
                   '{32'h00010018, 32'h00000007, 1'b0, 1'b0}};
        tbl[8] = '{"grp_b1", 32'h0000FFFF, 32'h0, 1'b1,
                   '{32'h00010000, 32'h0000FFFF, 1'b0, 1'b0}};
        tbl[9] = '{"zero", 32'h0, 32'h0, 1'b0,
                   '{32'h00000000, 32'h00000000, 1'b0, 1'b0}};

        bus.a  = 32'hFFFFFFFF;
        bus.b  = 32'h1;
        bus.c0 = 1'b1;
        #2 rst = 1'b1;
        #1 check("rst_async", outs(), zero);
        repeat (2) @(posedge clk);
        #1 check("rst_hold", outs(), zero);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_release", outs(),
                 '{32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0});

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].c0, tbl[i].exp);
        end

        for (int i = 0; i < 128; i++) begin
            for (int k = 0; k < 2; k++) begin
                e = model(i[31:0], 32'd65555, k[0]);
                e.s = i[31:0] + 32'd65555 + k[31:0];
                e.g = 1'b0;
                e.p = 1'b0;
                drive("small_add", i[31:0], 32'd65555, k[0], e);
            end
        end

        drive("pre_midrst", 32'h12345678, 32'h1, 1'b0,
              model(32'h12345678, 32'h1, 1'b0));
        @(negedge clk);
        bus.a  = 32'hDEADBEEF;
        bus.b  = 32'h11111111;
        bus.c0 = 1'b1;
        #2 rst = 1'b1;
        #1 check("midrst_async", outs(), zero);
        @(posedge clk);
        #1 check("midrst_edge", outs(), zero);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("midrst_release", outs(),
                 model(32'hDEADBEEF, 32'h11111111, 1'b1));

        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            if (n % 8 == 0) rb = ~ra;
            drive("random", ra, rb, rc, model(ra, rb, rc));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
